// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared decode constants, the D->E control bundle and the MDU FSM states
// for the pipelined RV32 main controller.
package ctrl_pkg;

   // Opcodes
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   // funct7 values accepted for R-type
   localparam logic [6:0] Func7Base = 7'b0000000;
   localparam logic [6:0] Func7Alt  = 7'b0100000;
   localparam logic [6:0] Func7Mdu  = 7'b0000001;

   // ALUOp
   localparam logic [1:0] AluOpAdd    = 2'b00;
   localparam logic [1:0] AluOpBranch = 2'b01;
   localparam logic [1:0] AluOpR      = 2'b10;
   localparam logic [1:0] AluOpI      = 2'b11;

   // resultSrc
   localparam logic [1:0] ResSrcAlu = 2'b00;
   localparam logic [1:0] ResSrcMem = 2'b01;
   localparam logic [1:0] ResSrcPc4 = 2'b10;
   localparam logic [1:0] ResSrcImm = 2'b11;

   // immSrc
   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   // branch condition
   localparam logic [2:0] BrNone = 3'b000;
   localparam logic [2:0] BrEq   = 3'b001;
   localparam logic [2:0] BrNe   = 3'b010;
   localparam logic [2:0] BrLt   = 3'b011;
   localparam logic [2:0] BrGe   = 3'b100;
   localparam logic [2:0] BrLtu  = 3'b101;
   localparam logic [2:0] BrGeu  = 3'b110;

   // jump kind
   localparam logic [1:0] JmpNone = 2'b00;
   localparam logic [1:0] JmpJal  = 2'b01;
   localparam logic [1:0] JmpJalr = 2'b10;

   // D->E control bundle (immSrc is consumed in D and illegal travels separately)
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       lui;
      logic       mdu;
      logic [1:0] result_src;
      logic [1:0] jump;
      logic [1:0] alu_op;
      logic [2:0] branch;
   } ctrl_t;

   typedef enum logic [1:0] {
      MduIdle = 2'b00,
      MduBusy = 2'b01,
      MduDone = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/pipe_main_controller_if.sv
// pipe_main_controller_if: decode-stage inputs (op/func3/func7, hazard stall/flush) and
// all D-stage, E-stage and MDU status outputs of the main controller.
//   master: pipeline/hazard side (drives instruction fields and stall/flush)
//   slave:  the controller
interface pipe_main_controller_if;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       stallE;
   logic       flushE;

   logic       regWriteD, memWriteD, ALUSrcD, luiD, mduD, illegalD;
   logic [1:0] resultSrcD, jumpD, ALUOpD;
   logic [2:0] branchD, immSrcD;

   logic       regWriteE, memWriteE, ALUSrcE, luiE, mduE, illegalE;
   logic [1:0] resultSrcE, jumpE, ALUOpE;
   logic [2:0] branchE;

   logic       mduBusy, mduDone, illegalFlag;

   modport master (
      output op, func3, func7, stallE, flushE,
      input  regWriteD, memWriteD, ALUSrcD, luiD, mduD, illegalD,
      input  resultSrcD, jumpD, ALUOpD, branchD, immSrcD,
      input  regWriteE, memWriteE, ALUSrcE, luiE, mduE, illegalE,
      input  resultSrcE, jumpE, ALUOpE, branchE,
      input  mduBusy, mduDone, illegalFlag
   );

   modport slave (
      input  op, func3, func7, stallE, flushE,
      output regWriteD, memWriteD, ALUSrcD, luiD, mduD, illegalD,
      output resultSrcD, jumpD, ALUOpD, branchD, immSrcD,
      output regWriteE, memWriteE, ALUSrcE, luiE, mduE, illegalE,
      output resultSrcE, jumpE, ALUOpE, branchE,
      output mduBusy, mduDone, illegalFlag
   );
endinterface

// File: rtl/main_decoder.sv
// main_decoder: purely combinational RV32I(+M) main decode.
//   op_i/func3_i/func7_i : instruction fields
//   ctrl_o               : control bundle, all zero for illegal encodings
//   imm_src_o            : immediate format select
//   illegal_o            : unsupported opcode/funct combination
module main_decoder
   import ctrl_pkg::*;
#(
   parameter bit EN_MDU = 1'b1
) (
   input  logic [6:0] op_i,
   input  logic [2:0] func3_i,
   input  logic [6:0] func7_i,
   output ctrl_t      ctrl_o,
   output logic [2:0] imm_src_o,
   output logic       illegal_o
);

   always_comb begin
      ctrl_o            = '0;
      ctrl_o.result_src = ResSrcAlu;
      ctrl_o.jump       = JmpNone;
      ctrl_o.alu_op     = AluOpAdd;
      ctrl_o.branch     = BrNone;
      imm_src_o         = ImmI;
      illegal_o         = 1'b0;

      case (op_i)
         OpR: begin
            if (func7_i == Func7Base || func7_i == Func7Alt) begin
               ctrl_o.alu_op    = AluOpR;
               ctrl_o.reg_write = 1'b1;
            end else if (EN_MDU && func7_i == Func7Mdu) begin
               ctrl_o.alu_op    = AluOpR;
               ctrl_o.reg_write = 1'b1;
               ctrl_o.mdu       = 1'b1;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OpImm: begin
            ctrl_o.alu_op    = AluOpI;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
         end
         OpLoad: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.result_src = ResSrcMem;
         end
         OpStore: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            imm_src_o        = ImmS;
         end
         OpBranch: begin
            case (func3_i)
               3'b000:  ctrl_o.branch = BrEq;
               3'b001:  ctrl_o.branch = BrNe;
               3'b100:  ctrl_o.branch = BrLt;
               3'b101:  ctrl_o.branch = BrGe;
               3'b110:  ctrl_o.branch = BrLtu;
               3'b111:  ctrl_o.branch = BrGeu;
               default: illegal_o     = 1'b1;
            endcase
            if (!illegal_o) begin
               ctrl_o.alu_op = AluOpBranch;
               imm_src_o     = ImmB;
            end
         end
         OpLui: begin
            ctrl_o.result_src = ResSrcImm;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.lui        = 1'b1;
            imm_src_o         = ImmU;
         end
         OpJal: begin
            ctrl_o.result_src = ResSrcPc4;
            ctrl_o.jump       = JmpJal;
            ctrl_o.reg_write  = 1'b1;
            imm_src_o         = ImmJ;
         end
         OpJalr: begin
            if (func3_i == 3'b000) begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.alu_src    = 1'b1;
               ctrl_o.jump       = JmpJalr;
               ctrl_o.result_src = ResSrcPc4;
            end else begin
               illegal_o = 1'b1;
            end
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_main_controller.sv
// pipe_main_controller: decode-stage main controller with registered D->E controls,
// MDU occupancy sequencer and sticky illegal-instruction flag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipe_main_controller_if (instruction fields, stallE/flushE in;
//              D/E controls, mduBusy, mduDone, illegalFlag out)
module pipe_main_controller
   import ctrl_pkg::*;
#(
   parameter int unsigned MDU_LATENCY = 4,
   parameter bit          EN_MDU      = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_main_controller_if.slave bus
);

   localparam int unsigned CntW = $clog2(MDU_LATENCY);
   // BUSY spans L-2 cycles; the counter counts down to zero before DONE.
   localparam logic [CntW-1:0] CntInit =
      CntW'((MDU_LATENCY > 2) ? (MDU_LATENCY - 3) : 0);

   ctrl_t      ctrl_dec;
   logic [2:0] imm_src_dec;
   logic       illegal_dec;

   main_decoder #(
      .EN_MDU(EN_MDU)
   ) u_main_decoder (
      .op_i      (bus.op),
      .func3_i   (bus.func3),
      .func7_i   (bus.func7),
      .ctrl_o    (ctrl_dec),
      .imm_src_o (imm_src_dec),
      .illegal_o (illegal_dec)
   );

   // E-stage register: flush beats stall
   ctrl_t ctrl_e_d, ctrl_e_q;
   logic  illegal_e_d, illegal_e_q;

   always_comb begin
      ctrl_e_d    = ctrl_e_q;
      illegal_e_d = illegal_e_q;
      if (bus.flushE) begin
         ctrl_e_d    = '0;
         illegal_e_d = 1'b0;
      end else if (!bus.stallE) begin
         ctrl_e_d    = ctrl_dec;
         illegal_e_d = illegal_dec;
      end
   end

   // MDU sequencer
   mdu_state_t      state_d, state_q;
   logic [CntW-1:0] cnt_d, cnt_q;
   logic            mdu_busy, mdu_done;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mdu_busy = 1'b0;
      mdu_done = 1'b0;
      unique case (state_q)
         MduIdle: begin
            if (ctrl_e_q.mdu) begin
               mdu_busy = 1'b1;
               if (MDU_LATENCY == 2) begin
                  state_d = MduDone;
               end else begin
                  state_d = MduBusy;
                  cnt_d   = CntInit;
               end
            end
         end
         MduBusy: begin
            mdu_busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = MduDone;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         MduDone: begin
            mdu_done = 1'b1;
            state_d  = MduIdle;
         end
         default: state_d = MduIdle;
      endcase
      // A flushed MDU op is abandoned; no completion pulse follows.
      if (bus.flushE) begin
         state_d = MduIdle;
         cnt_d   = '0;
      end
   end

   logic illegal_flag_d, illegal_flag_q;
   assign illegal_flag_d = illegal_flag_q | illegal_e_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_e_q       <= '0;
         illegal_e_q    <= 1'b0;
         state_q        <= MduIdle;
         cnt_q          <= '0;
         illegal_flag_q <= 1'b0;
      end else begin
         ctrl_e_q       <= ctrl_e_d;
         illegal_e_q    <= illegal_e_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         illegal_flag_q <= illegal_flag_d;
      end
   end

   assign bus.regWriteD  = ctrl_dec.reg_write;
   assign bus.memWriteD  = ctrl_dec.mem_write;
   assign bus.ALUSrcD    = ctrl_dec.alu_src;
   assign bus.luiD       = ctrl_dec.lui;
   assign bus.mduD       = ctrl_dec.mdu;
   assign bus.illegalD   = illegal_dec;
   assign bus.resultSrcD = ctrl_dec.result_src;
   assign bus.jumpD      = ctrl_dec.jump;
   assign bus.ALUOpD     = ctrl_dec.alu_op;
   assign bus.branchD    = ctrl_dec.branch;
   assign bus.immSrcD    = imm_src_dec;

   assign bus.regWriteE  = ctrl_e_q.reg_write;
   assign bus.memWriteE  = ctrl_e_q.mem_write;
   assign bus.ALUSrcE    = ctrl_e_q.alu_src;
   assign bus.luiE       = ctrl_e_q.lui;
   assign bus.mduE       = ctrl_e_q.mdu;
   assign bus.illegalE   = illegal_e_q;
   assign bus.resultSrcE = ctrl_e_q.result_src;
   assign bus.jumpE      = ctrl_e_q.jump;
   assign bus.ALUOpE     = ctrl_e_q.alu_op;
   assign bus.branchE    = ctrl_e_q.branch;

   assign bus.mduBusy     = mdu_busy;
   assign bus.mduDone     = mdu_done;
   assign bus.illegalFlag = illegal_flag_q;

endmodule

// File: tb/tb_pipe_main_controller.sv
// Scoreboard bench for pipe_main_controller. Three instances share the instruction stream:
//   dut0: L=4, MDU on; dut1: L=2, MDU on; dut2: L=4, MDU off.
// The bench plays the hazard unit: stallE = expected mduBusy | random stall.
module tb_pipe_main_controller;

   typedef logic [3*36-1:0] exp3_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op_drv = '0;
   logic [2:0] f3_drv = '0;
   logic [6:0] f7_drv = '0;
   logic       flush_drv = 1'b0;
   logic [2:0] stall_drv = '0;

   logic [35:0] obs [3];

   pipe_main_controller_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].op     = op_drv;
      assign bus[g].func3  = f3_drv;
      assign bus[g].func7  = f7_drv;
      assign bus[g].flushE = flush_drv;
      assign bus[g].stallE = stall_drv[g];

      pipe_main_controller #(
         .MDU_LATENCY((g == 1) ? 2 : 4),
         .EN_MDU     (g != 2)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus[g])
      );

      assign obs[g] = {bus[g].regWriteD, bus[g].memWriteD, bus[g].ALUSrcD, bus[g].luiD,
                       bus[g].mduD, bus[g].illegalD, bus[g].resultSrcD, bus[g].jumpD,
                       bus[g].ALUOpD, bus[g].branchD, bus[g].immSrcD,
                       bus[g].regWriteE, bus[g].memWriteE, bus[g].ALUSrcE, bus[g].luiE,
                       bus[g].mduE, bus[g].illegalE, bus[g].resultSrcE, bus[g].jumpE,
                       bus[g].ALUOpE, bus[g].branchE,
                       bus[g].mduBusy, bus[g].mduDone, bus[g].illegalFlag};
   end

   always #5 clk = ~clk;

   // Reference model state
   int          lat [3] = '{4, 2, 4};
   bit          en  [3] = '{1'b1, 1'b1, 1'b0};
   logic [14:0] e_m [3];
   int          ph  [3];   // 0: no MDU op running, n: n-th cycle after the op entered E
   bit          flag_m [3];
   logic [6:0]  prev_op, prev_f7;
   logic [2:0]  prev_f3, prev_stall;
   bit          prev_flush, rst_prev;

   exp3_t sb[$];
   int    n_checks = 0;
   int    n_pass = 0;

   // {rw,mw,alusrc,lui,mdu,illegal,resultSrc,jump,ALUOp,branch,immSrc}
   function automatic logic [17:0] ref_dec(logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                                           bit en_mdu);
      bit rw = 0, mw = 0, as = 0, lu = 0, md = 0, ill = 0;
      logic [1:0] rs = 0, jp = 0, ao = 0;
      logic [2:0] br = 0, imm = 0;
      logic [2:0] br_map [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
      case (o)
         7'h33: begin
            if (f7 == 7'h00 || f7 == 7'h20) begin ao = 2; rw = 1; end
            else if (en_mdu && f7 == 7'h01) begin ao = 2; rw = 1; md = 1; end
            else ill = 1;
         end
         7'h13: begin ao = 3; rw = 1; as = 1; end
         7'h03: begin rw = 1; as = 1; rs = 1; end
         7'h23: begin mw = 1; as = 1; imm = 1; end
         7'h63: begin
            if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
            else begin ao = 1; imm = 2; br = br_map[f3]; end
         end
         7'h37: begin rs = 3; imm = 4; rw = 1; lu = 1; end
         7'h6f: begin rs = 2; imm = 3; jp = 1; rw = 1; end
         7'h67: begin
            if (f3 == 3'd0) begin rw = 1; as = 1; jp = 2; rs = 2; end
            else ill = 1;
         end
         default: ill = 1;
      endcase
      return {rw, mw, as, lu, md, ill, rs, jp, ao, br, imm};
   endfunction

   task automatic check(string nm, int k, logic [17:0] act, logic [17:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
   endtask

   // One clock cycle: advance the model across the edge, then apply new inputs.
   task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input bit fl, input bit st, input bit rs);
      exp3_t x;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (!rst_prev) begin
            logic [17:0] d;
            flag_m[k] = flag_m[k] | e_m[k][9];
            if (prev_flush) ph[k] = 0;
            else if (ph[k] == 0) ph[k] = e_m[k][10] ? 1 : 0;
            else if (ph[k] == lat[k] - 1) ph[k] = 0;
            else ph[k] = ph[k] + 1;
            d = ref_dec(prev_op, prev_f3, prev_f7, en[k]);
            if (prev_flush) e_m[k] = '0;
            else if (!prev_stall[k]) e_m[k] = d[17:3];
         end
         if (rs) begin
            e_m[k] = '0; ph[k] = 0; flag_m[k] = 1'b0;
         end
      end
      rst = rs;
      for (int k = 0; k < 3; k++) begin
         bit bsy, dn;
         bsy = (ph[k] == 0 && e_m[k][10]) || (ph[k] >= 1 && ph[k] <= lat[k] - 2);
         dn  = (ph[k] == lat[k] - 1);
         stall_drv[k] = bsy | st;
         x[k*36 +: 36] = {ref_dec(o, f3, f7, en[k]), e_m[k], bsy, dn, flag_m[k]};
      end
      op_drv = o; f3_drv = f3; f7_drv = f7; flush_drv = fl;
      sb.push_back(x);
      prev_op = o; prev_f3 = f3; prev_f7 = f7; prev_flush = fl;
      prev_stall = stall_drv; rst_prev = rs;
   endtask

   task automatic rand_instr(output logic [6:0] o, output logic [2:0] f3,
                             output logic [6:0] f7);
      logic [6:0] ops [9] = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h67};
      int sel;
      sel = int'($urandom_range(0, 11));
      f3  = 3'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (sel < 9) o = ops[sel];
      else if (sel == 9) o = 7'($urandom_range(0, 127));
      else begin o = 7'h33; f7 = 7'h01; end
      if (sel == 1 && $urandom_range(0, 3) == 0) f7 = 7'($urandom_range(0, 127));
      if (o == 7'h67 && $urandom_range(0, 3) != 0) f3 = 3'd0;
   endtask

   // Monitor: one scoreboard entry per cycle, compared away from the edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp3_t x;
         x = sb.pop_front();
         for (int k = 0; k < 3; k++) begin
            check("decodeD", k, obs[k][35:18], x[k*36+18 +: 18]);
            check("stageE", k, {3'b0, obs[k][17:3]}, {3'b0, x[k*36+3 +: 15]});
            check("mdu_flag", k, {15'b0, obs[k][2:0]}, {15'b0, x[k*36 +: 3]});
         end
      end
   end

   initial begin
      logic [6:0] o, f7;
      logic [2:0] f3;
      for (int k = 0; k < 3; k++) begin
         e_m[k] = '0; ph[k] = 0; flag_m[k] = 1'b0;
      end
      prev_op = '0; prev_f3 = '0; prev_f7 = '0; prev_stall = '0;
      prev_flush = 1'b0; rst_prev = 1'b1;

      // Reset, then decode sweep and illegal opcode
      step(7'h00, 3'd0, 7'h00, 0, 0, 1);
      step(7'h00, 3'd0, 7'h00, 0, 0, 1);
      step(7'h03, 3'd0, 7'h00, 0, 0, 0);
      step(7'h63, 3'd6, 7'h00, 0, 0, 0);
      step(7'h7f, 3'd0, 7'h00, 0, 0, 0);
      step(7'h63, 3'd2, 7'h00, 0, 0, 0);
      // ADD then hold E for 3 cycles, then stall+flush together
      step(7'h33, 3'd0, 7'h00, 0, 0, 0);
      repeat (3) step(7'h13, 3'd0, 7'h00, 0, 1, 0);
      step(7'h13, 3'd0, 7'h00, 1, 1, 0);
      step(7'h13, 3'd0, 7'h00, 0, 0, 0);
      // Single MUL, then back-to-back MULs
      step(7'h33, 3'd0, 7'h01, 0, 0, 0);
      repeat (6) step(7'h13, 3'd1, 7'h00, 0, 0, 0);
      repeat (10) step(7'h33, 3'd0, 7'h01, 0, 0, 0);
      // MUL flushed while busy
      step(7'h33, 3'd0, 7'h01, 0, 0, 0);
      step(7'h13, 3'd0, 7'h00, 0, 0, 0);
      step(7'h13, 3'd0, 7'h00, 1, 0, 0);
      repeat (4) step(7'h13, 3'd0, 7'h00, 0, 0, 0);
      // MUL interrupted by reset while busy
      step(7'h33, 3'd0, 7'h01, 0, 0, 0);
      step(7'h13, 3'd0, 7'h00, 0, 0, 0);
      step(7'h13, 3'd0, 7'h00, 0, 0, 1);
      repeat (4) step(7'h13, 3'd0, 7'h00, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rand_instr(o, f3, f7);
         step(o, f3, f7, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 99) == 0);
      end

      repeat (2) @(posedge clk);
      check("scoreboard_drained", 0, 18'(sb.size()), 18'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_main_controller.md
# pipe_main_controller

Decode-stage main controller for the pipelined RV32 core, with a registered D→E control bundle and a multi-cycle multiply/divide (MDU) sequencer. It decodes `op`/`func3`/`func7` into D-stage controls and latches them into the E stage under hazard-unit stall/flush. It tracks MDU occupancy of E with a small FSM and flags illegal opcodes. It sits between the IF/ID register and the datapath/hazard unit.

## Interface
- `MDU_LATENCY`, 4, cycles an MDU instruction occupies E (legal range 2..16)
- `EN_MDU`, 1, 1 = decode M-extension (R-type with `func7`=0000001); 0 = treat it as illegal
- `clk` in 1 — the block's single clock
- `rst` in 1 — asynchronous, active-high reset
- `op` in 7 — D-stage opcode
- `func3` in 3 — D-stage funct3
- `func7` in 7 — D-stage funct7
- `stallE` in 1 — hold the E register
- `flushE` in 1 — load a bubble into E
- `regWriteD`, `memWriteD`, `ALUSrcD`, `luiD`, `mduD`, `illegalD` out 1 each — D-stage decode
- `resultSrcD`, `jumpD`, `ALUOpD` out 2 each — D-stage decode
- `branchD`, `immSrcD` out 3 each — D-stage decode
- `regWriteE`, `memWriteE`, `ALUSrcE`, `luiE`, `mduE`, `illegalE` out 1 each — E-stage registered controls
- `resultSrcE`, `jumpE`, `ALUOpE` out 2 each — E-stage registered controls
- `branchE` out 3 — E-stage registered control
- `mduBusy` out 1 — request to the hazard unit to stall F/D/E
- `mduDone` out 1 — one-cycle pulse: MDU result valid in E
- `illegalFlag` out 1 — sticky; set once an illegal instruction reaches E

## Operation
- Decode is combinational. All outputs default to 0; only the fields listed are set.
  - R (0110011): ALUOp=10, regWrite=1. With `EN_MDU` and `func7`=0000001, also mdu=1. Any other `func7` except 0000000/0100000 is illegal.
  - I-ALU (0010011): ALUOp=11, regWrite=1, ALUSrc=1, immSrc=000.
  - Load (0000011): ALUOp=00, regWrite=1, ALUSrc=1, immSrc=000, resultSrc=01.
  - Store (0100011): ALUOp=00, memWrite=1, ALUSrc=1, immSrc=001.
  - Branch (1100011): ALUOp=01, immSrc=010. `func3` maps as follows:
    - 000→001 BEQ, 001→010 BNE, 100→011 BLT, 101→100 BGE
    - 110→101 BLTU, 111→110 BGEU
    - 010/011 are illegal.
  - LUI (0110111): resultSrc=11, immSrc=100, regWrite=1, lui=1.
  - JAL (1101111): resultSrc=10, immSrc=011, jump=01, regWrite=1.
  - JALR (1100111, `func3`=000): ALUOp=00, regWrite=1, ALUSrc=1, immSrc=000, jump=10, resultSrc=10.
  - Any other opcode/funct combination: illegalD=1, all other controls 0. An illegal instruction never writes regfile or memory.
- E register priority: `rst` > `flushE` (load all-zero bubble) > `stallE` (hold) > load D values.
- MDU FSM, states IDLE/BUSY/DONE, counter `cnt` of width $clog2(MDU_LATENCY):
  - IDLE, `mduE`=1: if `MDU_LATENCY`==2 go DONE, else go BUSY with `cnt`=MDU_LATENCY-3.
  - BUSY: if `cnt`==0 go DONE, else decrement `cnt`.
  - DONE: go IDLE.
  - `mduBusy` = (IDLE & `mduE`) | BUSY. `mduDone` = DONE.
  - `flushE` in IDLE/BUSY/DONE: next state IDLE, no `mduDone` issued.
- `illegalFlag` is set on any cycle `illegalE`=1 and cleared only by `rst`.

## Timing
- D outputs: zero latency from `op`/`func3`/`func7`.
- E outputs: one cycle after capture (rising `clk`).
- An MDU instruction loaded into E at edge t0 produces:
  - `mduBusy`=1 for cycles t0..t0+L-2;
  - `mduDone`=1 in cycle t0+L-1 with `mduBusy`=0.
  - The hazard unit then releases the stall and E advances at the end of that cycle. The op is never retriggered.
- Back-to-back MDU ops: the FSM re-enters BUSY from IDLE on the next instruction. There is exactly one idle-free gap: the DONE cycle.
- Reset: every E output, `mduBusy`, `mduDone`, `illegalFlag` = 0; FSM = IDLE; `cnt` = 0. This applies mid-operation, asynchronously.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode localparams;
  - ALUOp/resultSrc/immSrc/branch/jump encodings;
  - packed struct `ctrl_t` (the D→E bundle);
  - enum `mdu_state_t`.
- One sub-module, `main_decoder`: purely combinational decode producing a `ctrl_t` plus `immSrc` and `illegal`. The top holds the E register, the FSM and the sticky flag.

## Test plan
- Decode sweep: `op`=0000011 → regWriteD=1, ALUSrcD=1, resultSrcD=01, immSrcD=000. `op`=1100011, `func3`=110 → branchD=101, ALUOpD=01.
- Illegal: `op`=1111111 → illegalD=1, all other D outputs 0. The next edge gives illegalE=1, then `illegalFlag` stays 1 until `rst`.
- Stall/flush: load ADD, then hold `stallE`=1 for 3 cycles → E outputs unchanged. Assert `stallE` and `flushE` together → E becomes all zeros.
- MDU with L=4: MUL (`func7`=0000001) captured at t0 → `mduBusy`=1 at t0..t0+2, `mduDone`=1 at t0+3, then IDLE. With `EN_MDU`=0 the same op gives illegalD=1.
- MDU with L=2: `mduBusy` for 1 cycle, then `mduDone`. A back-to-back second MUL gives busy again in the cycle after DONE.
- `flushE` or `rst` in BUSY → FSM IDLE next cycle, `mduDone` never pulses, `mduBusy`=0.
